harmonic_product_spectrum_n: RTL and testbench
==============================================

Name: harmonic_product_spectrum_n

Overview:
Parametrised N-harmonic product spectrum pitch estimator. It buffers the first half of one DFT magnitude frame, then, for every candidate bin k in a runtime-programmable inclusive range, forms the product of magnitudes at k, 2k, ..., N·k. It reports the argmax k and its product. It sits downstream of the complex-magnitude stage and feeds the pitch-shift ratio logic. It replaces the fixed 3-harmonic, fixed-range version with back-pressure and full-precision products.

Parameters:
K_WIDTH, 11, DFT index width; DFT length 2^K_WIDTH, buffered half HALF = 2^(K_WIDTH-1) bins
MAG_WIDTH, 32, unsigned magnitude width
N_HARMONICS, 3, harmonics multiplied per candidate; legal range 1..5
PROD_WIDTH, MAG_WIDTH*N_HARMONICS, product/max width (derived, do not override)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mag_tdata  in  MAG_WIDTH  unsigned magnitude
mag_tuser  in  K_WIDTH  DFT bin index of mag_tdata
mag_tvalid  in  1  AXI-S valid
mag_tlast  in  1  last beat of frame
mag_tready  out  1  AXI-S ready
cfg_k_min  in  K_WIDTH-1  lowest candidate k (inclusive), sampled at tlast handshake
cfg_k_max  in  K_WIDTH-1  highest candidate k (inclusive), sampled at tlast handshake
busy  out  1  high while in PROCESS
k_max  out  K_WIDTH  argmax bin; MSB always 0
max_product  out  PROD_WIDTH  product at k_max
k_max_valid  out  1  one-cycle result strobe

Behaviour:
- Reset (async, reset_n=0): state=STORE, mag_tready=1, busy=0, k_max=0, max_product=0, k_max_valid=0, all counters and accumulators 0. Magnitude RAM contents are not cleared.
- States: STORE -> PROCESS -> DONE -> STORE.
- STORE:
  - mag_tready=1.
  - On a handshake (valid&ready) with mag_tuser[K_WIDTH-1]=0, write mag_tdata to RAM[mag_tuser[K_WIDTH-2:0]]. Beats with the MSB set are accepted and discarded.
  - Duplicate indices: last write wins. Bins not written this frame keep their previous value.
  - On a handshake with mag_tlast=1: latch cfg_k_min and cfg_k_max, then go to PROCESS next cycle.
- PROCESS:
  - mag_tready=0, busy=1. Upstream stalls; no data is dropped.
  - Effective range: k_lo=max(cfg_k_min,1), k_hi=cfg_k_max. If k_lo>k_hi, skip directly to DONE with k_max=0 and max_product=0.
  - Per candidate k:
    - Issue N_HARMONICS RAM reads on consecutive cycles at addresses h·k, h=1..N_HARMONICS. The address is generated by repeated addition in a register of width K_WIDTH+3, with no multiplier.
    - RAM read latency is 1 cycle.
    - The accumulator starts at 1 and multiplies in each returned magnitude at full precision (PROD_WIDTH, no truncation).
    - Any h·k >= HALF contributes factor 0.
    - One compare cycle follows the last multiply. If acc > running max (strictly greater), update both the max and its k; ties keep the lower k.
    - The running max starts at 0 and the argmax starts at 0 for each frame. A frame whose products are all 0 reports k_max=0.
  - Cost is exactly N_HARMONICS+2 cycles per candidate; candidates are not overlapped.
- DONE (1 cycle):
  - Register the results into k_max and max_product; pulse k_max_valid=1 for exactly one cycle.
  - busy=0. Return to STORE; mag_tready=1 from the following cycle.
- Result timing: k_max_valid asserts exactly (k_hi-k_lo+1)·(N_HARMONICS+2)+2 cycles after the tlast handshake cycle, or 2 cycles for an empty range.
- Output hold: k_max and max_product hold until the next DONE.
- Config timing: cfg_* changes outside the tlast handshake cycle have no effect on the frame in flight.
- Reset mid-PROCESS: abort immediately, no k_max_valid, outputs return to reset values.

Test Plan:
- N=3, K_WIDTH=6, MAG_WIDTH=8, cfg 1..31; bins 0..31 all =1 except bins 5,10,15 =4 -> k_max_valid once, k_max=5, max_product=64, latency 31·5+2=157 cycles after tlast.
- Same frame, cfg_k_min=6, cfg_k_max=31 -> k_max=10, max_product=4.
  - k=15 scores 0 because bin 45 >= HALF.
- All bins =2, cfg 1..10 -> k_max=1, max_product=8.
  - k=10 ties at 8 and loses on the tie rule.
- cfg_k_min=12, cfg_k_max=8 -> k_max=0, max_product=0, valid 2 cycles after tlast.
- Back-pressure: hold mag_tvalid=1 with the next frame during PROCESS -> mag_tready=0 and busy=1 until DONE.
  - No RAM write occurs while mag_tready=0.
  - The second frame's result is independent of the first.
  - Beats with tuser >= 32 are accepted but never written.
- Assert reset_n=0 mid-PROCESS, then release, then send a fresh frame:
  - No valid pulse during the aborted frame.
  - k_max=0 after reset.
  - The fresh frame gives the correct result.

Source files
------------

// File: rtl/harmonic_product_spectrum_n.sv
// N-harmonic product spectrum pitch estimator: buffers the lower half of a DFT
// magnitude frame, then scores each candidate bin k by the product of |X[h*k]|.
module harmonic_product_spectrum_n #(
  parameter int K_WIDTH     = 11,
  parameter int MAG_WIDTH   = 32,
  parameter int N_HARMONICS = 3,
  parameter int PROD_WIDTH  = MAG_WIDTH * N_HARMONICS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [MAG_WIDTH-1:0]  mag_tdata,
  input  logic [K_WIDTH-1:0]    mag_tuser,
  input  logic                  mag_tvalid,
  input  logic                  mag_tlast,
  output logic                  mag_tready,
  input  logic [K_WIDTH-2:0]    cfg_k_min,
  input  logic [K_WIDTH-2:0]    cfg_k_max,
  output logic                  busy,
  output logic [K_WIDTH-1:0]    k_max,
  output logic [PROD_WIDTH-1:0] max_product,
  output logic                  k_max_valid
);

  localparam int HALF = 2 ** (K_WIDTH - 1);
  localparam int KW   = K_WIDTH - 1;
  localparam int AW   = K_WIDTH + 3;
  localparam logic [2:0] PH_LAST_RD = 3'(N_HARMONICS - 1);
  localparam logic [2:0] PH_LAST_MUL = 3'(N_HARMONICS);
  localparam logic [2:0] PH_CMP = 3'(N_HARMONICS + 1);

  typedef enum logic [1:0] {ST_STORE, ST_PROCESS, ST_DONE} state_t;

  state_t                state_q;
  logic                  tready_q, busy_q, valid_q, init_q, oor_q;
  logic [KW-1:0]         cfg_lo_q, cfg_hi_q, k_q, arg_q, kmax_q;
  logic [AW-1:0]         addr_q;
  logic [2:0]            ph_q;
  logic [PROD_WIDTH-1:0] acc_q, best_q, maxp_q;
  logic [MAG_WIDTH-1:0]  rd_q;
  logic [MAG_WIDTH-1:0]  ram [HALF];

  logic [KW-1:0]         k_lo_d;
  logic [MAG_WIDTH-1:0]  factor_d;
  logic [PROD_WIDTH-1:0] acc_d;
  logic                  better_d, addr_oor_d, wr_en_d;

  always_comb begin
    k_lo_d     = (cfg_lo_q == '0) ? KW'(1) : cfg_lo_q;
    factor_d   = oor_q ? '0 : rd_q;
    acc_d      = acc_q * PROD_WIDTH'(factor_d);
    better_d   = acc_q > best_q;
    addr_oor_d = addr_q >= AW'(HALF);
    wr_en_d    = mag_tvalid && tready_q && !mag_tuser[K_WIDTH-1];
  end

  // Magnitude buffer; one read per cycle with one cycle of latency.
  always_ff @(posedge clock) begin
    if (wr_en_d) ram[mag_tuser[KW-1:0]] <= mag_tdata;
    rd_q <= ram[addr_q[KW-1:0]];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_STORE;
      tready_q <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      init_q   <= 1'b0;
      oor_q    <= 1'b0;
      cfg_lo_q <= '0;
      cfg_hi_q <= '0;
      k_q      <= '0;
      arg_q    <= '0;
      kmax_q   <= '0;
      addr_q   <= '0;
      ph_q     <= '0;
      acc_q    <= '0;
      best_q   <= '0;
      maxp_q   <= '0;
    end else begin
      oor_q <= addr_oor_d;
      case (state_q)
        ST_STORE: begin
          if (mag_tvalid && tready_q && mag_tlast) begin
            cfg_lo_q <= cfg_k_min;
            cfg_hi_q <= cfg_k_max;
            tready_q <= 1'b0;
            busy_q   <= 1'b1;
            init_q   <= 1'b1;
            state_q  <= ST_PROCESS;
          end
        end
        ST_PROCESS: begin
          if (init_q) begin
            init_q <= 1'b0;
            if (k_lo_d > cfg_hi_q) begin
              kmax_q  <= '0;
              maxp_q  <= '0;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              k_q    <= k_lo_d;
              addr_q <= AW'(k_lo_d);
              ph_q   <= '0;
              acc_q  <= PROD_WIDTH'(1);
              best_q <= '0;
              arg_q  <= '0;
            end
          end else begin
            // Phases 0..N-1 issue reads, 1..N multiply, N+1 compares.
            if (ph_q <= PH_LAST_RD) addr_q <= addr_q + AW'(k_q);
            if (ph_q >= 3'd1 && ph_q <= PH_LAST_MUL) acc_q <= acc_d;
            if (ph_q == PH_CMP) begin
              if (better_d) begin
                best_q <= acc_q;
                arg_q  <= k_q;
              end
              if (k_q == cfg_hi_q) begin
                kmax_q  <= better_d ? k_q : arg_q;
                maxp_q  <= better_d ? acc_q : best_q;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_DONE;
              end else begin
                k_q    <= k_q + KW'(1);
                addr_q <= AW'(k_q) + AW'(1);
                ph_q   <= '0;
                acc_q  <= PROD_WIDTH'(1);
              end
            end else begin
              ph_q <= ph_q + 3'd1;
            end
          end
        end
        ST_DONE: begin
          valid_q  <= 1'b0;
          tready_q <= 1'b1;
          state_q  <= ST_STORE;
        end
        default: state_q <= ST_STORE;
      endcase
    end
  end

  assign mag_tready  = tready_q;
  assign busy        = busy_q;
  assign k_max       = {1'b0, kmax_q};
  assign max_product = maxp_q;
  assign k_max_valid = valid_q;

endmodule

// File: tb/tb_harmonic_product_spectrum_n.sv
// Directed, table-driven bench for harmonic_product_spectrum_n (N=3, 64-point DFT, 8-bit mags).
module tb_harmonic_product_spectrum_n;

  localparam int KW = 6;
  localparam int MW = 8;
  localparam int NH = 3;
  localparam int PW = MW * NH;

  logic          clock;
  logic          reset_n;
  logic [MW-1:0] mag_tdata;
  logic [KW-1:0] mag_tuser;
  logic          mag_tvalid;
  logic          mag_tlast;
  logic          mag_tready;
  logic [KW-2:0] cfg_k_min;
  logic [KW-2:0] cfg_k_max;
  logic          busy;
  logic [KW-1:0] k_max;
  logic [PW-1:0] max_product;
  logic          k_max_valid;

  harmonic_product_spectrum_n #(
    .K_WIDTH(KW), .MAG_WIDTH(MW), .N_HARMONICS(NH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .mag_tdata(mag_tdata), .mag_tuser(mag_tuser), .mag_tvalid(mag_tvalid),
    .mag_tlast(mag_tlast), .mag_tready(mag_tready),
    .cfg_k_min(cfg_k_min), .cfg_k_max(cfg_k_max),
    .busy(busy), .k_max(k_max), .max_product(max_product), .k_max_valid(k_max_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // kind 0: all ones except bins 5,10,15 = 4; kind 1: all twos
  function automatic logic [MW-1:0] fval(input int kind, input int b);
    if (kind == 0) return (b == 5 || b == 10 || b == 15) ? 8'd4 : 8'd1;
    return 8'd2;
  endfunction

  task automatic send_beat(input logic [MW-1:0] d, input logic [KW-1:0] u, input logic last,
                           input logic [KW-2:0] kmn, input logic [KW-2:0] kmx);
    int w;
    @(negedge clock);
    mag_tdata  = d;
    mag_tuser  = u;
    mag_tlast  = last;
    mag_tvalid = 1'b1;
    cfg_k_min  = kmn;
    cfg_k_max  = kmx;
    w = 0;
    while (!mag_tready && w < 1000) begin
      @(negedge clock);
      w++;
    end
    if (w >= 1000) chk("ready_timeout", 64'(w), 64'd0);
    @(posedge clock);
  endtask

  // Ends on the negedge right after the tlast handshake; c0 = cycle count there.
  task automatic finish_frame(output int c0);
    @(negedge clock);
    mag_tvalid = 1'b0;
    mag_tlast  = 1'b0;
    cfg_k_min  = 5'd3;
    cfg_k_max  = 5'd20;
    c0 = cyc;
  endtask

  task automatic send_frame(input int kind, input int kmin, input int kmax, output int c0);
    for (int b = 0; b < 32; b++) begin
      if (b == 31) send_beat(fval(kind, b), 6'(b), 1'b1, 5'(kmin), 5'(kmax));
      else         send_beat(fval(kind, b), 6'(b), 1'b0, 5'd0, 5'd31);
    end
    finish_frame(c0);
  endtask

  task automatic wait_result(input string nm, input int c0, input int ek, input int ep,
                             input int elat);
    int lat;
    int bad;
    logic got;
    got = 1'b0;
    bad = 0;
    lat = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clock);
      if (k_max_valid) begin
        got = 1'b1;
        lat = cyc - c0 + 1;
      end else if (busy !== 1'b1 || mag_tready !== 1'b0) begin
        bad++;
      end
    end
    chk({nm, "_got_valid"}, 64'(got), 64'd1);
    if (got) begin
      chk({nm, "_k_max"}, 64'(k_max), 64'(ek));
      chk({nm, "_max_product"}, 64'(max_product), 64'(ep));
      chk({nm, "_latency"}, 64'(lat), 64'(elat));
      chk({nm, "_busy_in_done"}, 64'(busy), 64'd0);
      chk({nm, "_stall_cycles_bad"}, 64'(bad), 64'd0);
      @(negedge clock);
      chk({nm, "_valid_one_cycle"}, 64'(k_max_valid), 64'd0);
      chk({nm, "_ready_after_done"}, 64'(mag_tready), 64'd1);
      chk({nm, "_hold_k"}, 64'(k_max), 64'(ek));
      chk({nm, "_hold_p"}, 64'(max_product), 64'(ep));
    end
  endtask

  typedef struct {
    int kind;
    int kmin;
    int kmax;
    int ek;
    int ep;
    int elat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c0;
    int cnt;
    int bad;

    vecs[0] = '{0, 1, 31, 5, 64, 157};
    vecs[1] = '{0, 6, 31, 10, 4, 132};
    vecs[2] = '{1, 1, 10, 1, 8, 52};
    vecs[3] = '{0, 12, 8, 0, 0, 2};
    vecs[4] = '{0, 5, 5, 5, 64, 7};
    vecs[5] = '{0, 0, 0, 0, 0, 2};
    vecs[6] = '{0, 0, 4, 1, 1, 22};
    vecs[7] = '{0, 11, 31, 0, 0, 107};

    reset_n    = 1'b0;
    mag_tdata  = '0;
    mag_tuser  = '0;
    mag_tvalid = 1'b0;
    mag_tlast  = 1'b0;
    cfg_k_min  = '0;
    cfg_k_max  = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", 64'(mag_tready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_k_max", 64'(k_max), 64'd0);
    chk("rst_max_product", 64'(max_product), 64'd0);
    chk("rst_valid", 64'(k_max_valid), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].kind, vecs[i].kmin, vecs[i].kmax, c0);
      wait_result($sformatf("vec%0d", i), c0, vecs[i].ek, vecs[i].ep, vecs[i].elat);
    end

    // Back-pressure: next frame's first beat held valid while the current one is scored.
    send_frame(0, 1, 31, c0);
    mag_tdata  = 8'd0;
    mag_tuser  = 6'd5;
    mag_tlast  = 1'b0;
    mag_tvalid = 1'b1;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 2000 && cnt == 0; i++) begin
      @(negedge clock);
      if (k_max_valid) cnt = cyc - c0 + 1;
      else if (mag_tready !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("bp_stall_cycles_bad", 64'(bad), 64'd0);
    chk("bp_latency", 64'(cnt), 64'd157);
    chk("bp_k_max", 64'(k_max), 64'd5);
    chk("bp_max_product", 64'(max_product), 64'd64);
    chk("bp_ready_in_done", 64'(mag_tready), 64'd0);
    @(negedge clock);
    chk("bp_ready_restored", 64'(mag_tready), 64'd1);
    @(posedge clock);
    for (int b = 0; b < 31; b++) send_beat(8'd2, 6'(b), 1'b0, 5'd0, 5'd31);
    send_beat(8'd200, 6'd33, 1'b0, 5'd0, 5'd31);
    send_beat(8'd200, 6'd37, 1'b0, 5'd0, 5'd31);
    send_beat(8'd2, 6'd31, 1'b1, 5'd1, 5'd10);
    finish_frame(c0);
    wait_result("bp_frame2", c0, 1, 8, 52);

    // Reset while scoring: no strobe, outputs cleared, next frame unaffected.
    send_frame(0, 1, 31, c0);
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (k_max_valid) cnt++;
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_k_max", 64'(k_max), 64'd0);
    chk("midrst_max_product", 64'(max_product), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(mag_tready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (200) begin
      @(negedge clock);
      if (k_max_valid) cnt++;
    end
    chk("midrst_no_valid", 64'(cnt), 64'd0);
    send_frame(0, 6, 31, c0);
    wait_result("after_rst", c0, 10, 4, 132);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
